alu_seq: RTL

- Parametrised, registered successor to the datapath's combinational 16-bit ALU.
- Widens the opcode to 3 bits, adds OR/XOR/shift-left and an iterative multiply, and registers the result and status flags (Z, N, V).
- Uses a start/busy/done handshake.
- Sits between the register-file read ports and the writeback mux; the controller FSM waits on done before writeback and status-register load.

---
 rtl/alu_seq.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq -- registered ALU with an iterative shift-and-add multiplier.
//
// Single-cycle ops (ADD/SUB/AND/NOT/OR/XOR/SHL) complete on the edge that
// accepts start. MUL takes WIDTH edges, one multiplier bit per edge.
// Result and flags are registered and change only together with a done pulse.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset, priority over everything
//   start  in   request, sampled while busy=0
//   ALUop  in   [2:0] operation select, sampled with start
//   Ain    in   [WIDTH-1:0] operand A, sampled with start
//   Bin    in   [WIDTH-1:0] operand B, sampled with start
//   out    out  [WIDTH-1:0] registered result
//   Z      out  zero flag (out == 0)
//   N      out  negative flag (out[WIDTH-1])
//   V      out  signed overflow (ADD/SUB only, 0 otherwise)
//   busy   out  high while a multiply is in progress
//   done   out  one-cycle pulse when out/Z/N/V were just updated
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALUop,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  output logic [WIDTH-1:0] out,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [SHW-1:0]   cnt_reg;
  logic [WIDTH-1:0] out_reg;
  logic             z_reg;
  logic             n_reg;
  logic             v_reg;
  logic             done_reg;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_v;
  logic [WIDTH-1:0] acc_step;
  logic             last_iter;
  logic             mul_accept;
  logic             load_out;
  logic [WIDTH-1:0] res_next;
  logic             v_next;

  assign sum  = Ain + Bin;
  assign diff = Ain - Bin;

  // Accumulator value after this edge's partial product is added.
  assign acc_step  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  // Counter holds the number of iterations already done; the WIDTH-th edge
  // is the one where it reads WIDTH-1.
  assign last_iter = (cnt_reg == SHW'(WIDTH - 1));
  assign mul_accept = (state_reg == IDLE) && start && (ALUop == OP_MUL);

  // Single-cycle result path. MUL and any unknown opcode fall to the default
  // branch so a garbage opcode can only ever produce zero.
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (ALUop)
      OP_ADD: begin
        alu_res = sum;
        alu_v   = (Ain[WIDTH-1] == Bin[WIDTH-1]) && (sum[WIDTH-1] != Ain[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_v   = (Ain[WIDTH-1] != Bin[WIDTH-1]) && (diff[WIDTH-1] != Ain[WIDTH-1]);
      end
      OP_AND:  alu_res = Ain & Bin;
      OP_NOT:  alu_res = ~Bin;
      OP_OR:   alu_res = Ain | Bin;
      OP_XOR:  alu_res = Ain ^ Bin;
      OP_SHL:  alu_res = Ain << Bin[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (mul_accept) state_next = MUL;
      MUL:     if (last_iter) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output-side decode: decides when the result registers load and with what.
  always_comb begin
    load_out = 1'b0;
    res_next = out_reg;
    v_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && (ALUop != OP_MUL)) begin
          load_out = 1'b1;
          res_next = alu_res;
          v_next   = alu_v;
        end
      end
      MUL: begin
        if (last_iter) begin
          load_out = 1'b1;
          res_next = acc_step;
          v_next   = 1'b0;
        end
      end
      default: begin
        load_out = 1'b0;
      end
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      out_reg    <= '0;
      z_reg      <= 1'b0;
      n_reg      <= 1'b0;
      v_reg      <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= load_out;
      if (load_out) begin
        out_reg <= res_next;
        z_reg   <= (res_next == '0);
        n_reg   <= res_next[WIDTH-1];
        v_reg   <= v_next;
      end
      if (mul_accept) begin
        mcand_reg  <= Ain;
        mplier_reg <= Bin;
        acc_reg    <= '0;
        cnt_reg    <= '0;
      end else if (state_reg == MUL) begin
        acc_reg    <= acc_step;
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        cnt_reg    <= cnt_reg + SHW'(1);
      end
    end
  end

  assign out  = out_reg;
  assign Z    = z_reg;
  assign N    = n_reg;
  assign V    = v_reg;
  assign busy = (state_reg == MUL);
  assign done = done_reg;

endmodule
